// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one MOV/MOC memory port between fetch and data requesters.
// Optional BUSY timeout abort enabled by defining MEM_ARB_TIMEOUT_EN (TIMEOUT cycles, 1..255).
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_moc,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;
  logic   last_gnt;  // 1 = data won the most recent grant, 0 = fetch
  logic   grant_d;
  logic   tmo_hit;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be within 1..255");
  end

  // On a tie the requester that did not win last time gets the port.
  always_comb grant_d = d_req && (!i_req || !last_gnt);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       timed_out;

  always_comb tmo_hit = (state == BUSY) && !mem_moc && (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt   <= 8'd0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt   <= 8'd0;
          timed_out <= 1'b0;
        end
        BUSY: begin
          if (!mem_moc) tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_hit)  timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb err = (state == DONE) && timed_out;
`else
  always_comb tmo_hit = 1'b0;
  always_comb err     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nx = BUSY;
      BUSY:    if (mem_moc || tmo_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      mem_rw    <= 1'b1;
      mem_size  <= 2'b10;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rdata     <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (i_req || d_req)) begin
        last_gnt <= grant_d;
        if (grant_d) begin
          mem_rw    <= d_rw;
          mem_size  <= d_size;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_rw   <= 1'b1;
          mem_size <= 2'b10;
          mem_addr <= i_addr;
        end
      end
      // MOC wins over a timeout landing on the same edge.
      if (state == BUSY) begin
        if (mem_moc) begin
          if (mem_rw) rdata <= mem_rdata;
        end else if (tmo_hit) begin
          rdata <= 32'h0;
        end
      end
    end
  end

  always_comb begin
    mem_mov = (state == BUSY);
    i_done  = (state == DONE) && !last_gnt;
    d_done  = (state == DONE) && last_gnt;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level timing model plus directed tests.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b1;
  logic [1:0]  d_size = 2'b10;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_mov;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_moc = 1'b0;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .err(err),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_moc(mem_moc), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Memory: asserts MOC in the (wait_cfg+1)-th consecutive BUSY cycle.
  int          wait_cfg = 0;
  logic [31:0] mem_val = 32'h0;
  logic        stray_moc = 1'b0;
  int          busy_idx = 0;
  logic        prev_mov = 1'b0;
  assign mem_rdata = mem_val;

  always @(posedge clk) begin
    #2;
    if (mem_mov) begin
      busy_idx = prev_mov ? busy_idx + 1 : 0;
      mem_moc  = (busy_idx == wait_cfg);
    end else begin
      mem_moc = stray_moc;
    end
    prev_mov = mem_mov;
  end

  // Model: each granted access occupies a window of cycles computed from the memory's wait count.
  logic        model_ok = 1'b0;
  int          m_idle_from = 0, m_mov_from = -1, m_done_at = -1, len;
  logic        m_win_d = 1'b0, m_last = 1'b0, m_err = 1'b0, m_rw = 1'b1;
  logic [1:0]  m_size = 2'b10;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_ok = 1'b1;
      m_idle_from = cyc; m_mov_from = -1; m_done_at = -1;
      m_last = 1'b0; m_err = 1'b0; m_win_d = 1'b0;
      m_rw = 1'b1; m_size = 2'b10; m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    end else if (model_ok) begin
      if (cyc == m_done_at) begin
        if (m_err) m_rdata = 32'h0;
        else if (m_rw) m_rdata = mem_val;
      end
      if (cyc - 1 >= m_idle_from && (i_req || d_req)) begin
        m_win_d = d_req && !(i_req && m_last);
        m_last  = m_win_d;
        if (m_win_d) begin
          m_rw = d_rw; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
        end else begin
          m_rw = 1'b1; m_size = 2'b10; m_addr = i_addr;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        m_err = (wait_cfg > TO - 1);
        len   = m_err ? TO : wait_cfg + 1;
`else
        m_err = 1'b0;
        len   = wait_cfg + 1;
`endif
        m_mov_from  = cyc;
        m_done_at   = cyc + len;
        m_idle_from = cyc + len + 1;
      end
    end
  end

  int   n_mov_total = 0;
  int   n_err_total = 0;
  logic exp_mov;

  always @(negedge clk) begin
    if (model_ok) begin
      exp_mov = (cyc >= m_mov_from) && (cyc < m_done_at);
      chk("mem_mov", {31'h0, mem_mov}, {31'h0, exp_mov});
      chk("i_done", {31'h0, i_done}, {31'h0, (cyc == m_done_at) && !m_win_d});
      chk("d_done", {31'h0, d_done}, {31'h0, (cyc == m_done_at) && m_win_d});
      chk("err", {31'h0, err}, {31'h0, (cyc == m_done_at) && m_err});
      chk("rdata", rdata, m_rdata);
      chk("mem_rw", {31'h0, mem_rw}, {31'h0, m_rw});
      chk("mem_size", {30'h0, mem_size}, {30'h0, m_size});
      chk("mem_addr", mem_addr, m_addr);
      if (exp_mov && !m_rw) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (mem_mov) n_mov_total++;
    if (err) n_err_total++;
  end

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout at cycle %0d: no done within %0d cycles", cyc, budget);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk); #1 reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int t0, at, mv0, er0;
  logic [3:0] seq;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mov", {31'h0, mem_mov}, 32'h0);
    chk("rst_rw", {31'h0, mem_rw}, 32'h1);
    chk("rst_size", {30'h0, mem_size}, 32'h2);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", {30'h0, i_done, d_done}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Fetch, zero-wait memory
    wait_cfg = 0; mem_val = 32'h8C22_0004; mv0 = n_mov_total;
    #1 i_addr = 32'h0000_0010; i_req = 1'b1; t0 = cyc;
    wait_done(20, at);
    @(posedge clk); #1 i_req = 1'b0;
    chk("fetch_latency", at - t0, 32'd2);
    chk("fetch_rdata", rdata, 32'h8C22_0004);
    chk("fetch_mov_cycles", n_mov_total - mv0, 32'd1);

    // Byte store with 3 wait states; stray MOC outside BUSY must be ignored
    repeat (2) @(posedge clk);
    stray_moc = 1'b1;
    repeat (3) @(posedge clk);
    wait_cfg = 3; mem_val = 32'hDEAD_BEEF; mv0 = n_mov_total;
    #1 d_rw = 1'b0; d_size = 2'b00; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D; d_req = 1'b1; t0 = cyc;
    wait_done(20, at);
    @(posedge clk); #1 d_req = 1'b0;
    chk("store_latency", at - t0, 32'd5);
    chk("store_mov_cycles", n_mov_total - mv0, 32'd4);
    chk("store_rdata_kept", rdata, 32'h8C22_0004);
    repeat (3) @(posedge clk);
    stray_moc = 1'b0;

    // Both requesting from reset: D, I, D, I
    pulse_reset(2);
    wait_cfg = 1; mem_val = 32'h1234_5678;
    #1 d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h100; i_addr = 32'h200; i_req = 1'b1; d_req = 1'b1;
    seq = 4'h0;
    for (int k = 0; k < 4; k++) begin
      wait_done(20, at);
      seq = {seq[2:0], d_done};
      chk("rr_single_done", {30'h0, i_done, d_done} == 32'h3 ? 32'h1 : 32'h0, 32'h0);
    end
    @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
    chk("rr_order", {28'h0, seq}, 32'hA);

    // Data requester drops req while BUSY: access still completes
    repeat (2) @(posedge clk);
    wait_cfg = 2; mem_val = 32'h0BAD_F00D;
    #1 d_rw = 1'b1; d_size = 2'b01; d_addr = 32'h80; d_req = 1'b1; t0 = cyc;
    repeat (2) @(posedge clk);
    #1 d_req = 1'b0;
    wait_done(20, at);
    chk("drop_latency", at - t0, 32'd4);
    chk("drop_rdata", rdata, 32'h0BAD_F00D);

    // Reset in the second BUSY cycle abandons the access
    repeat (2) @(posedge clk);
    wait_cfg = 5; mem_val = 32'h5555_AAAA;
    #1 d_addr = 32'h300; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy_mov", {31'h0, mem_mov}, 32'h0);
    chk("rst_busy_done", {30'h0, i_done, d_done}, 32'h0);
    wait_cfg = 0; mem_val = 32'h0000_C0DE;
    @(posedge clk); #1 i_addr = 32'h44; i_req = 1'b1; t0 = cyc;
    wait_done(20, at);
    @(posedge clk); #1 i_req = 1'b0;
    chk("post_rst_latency", at - t0, 32'd2);
    chk("post_rst_rdata", rdata, 32'h0000_C0DE);

`ifdef MEM_ARB_TIMEOUT_EN
    // MOC never comes: abort after TO BUSY cycles
    repeat (2) @(posedge clk);
    wait_cfg = 1000; mem_val = 32'hFFFF_FFFF; mv0 = n_mov_total; er0 = n_err_total;
    #1 d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h500; d_req = 1'b1; t0 = cyc;
    wait_done(20, at);
    chk("tmo_err_with_done", {30'h0, err, d_done}, 32'h3);
    @(posedge clk); #1 d_req = 1'b0;
    chk("tmo_latency", at - t0, 32'd5);
    chk("tmo_mov_cycles", n_mov_total - mv0, 32'd4);
    chk("tmo_rdata", rdata, 32'h0);
    // MOC on the last allowed BUSY cycle completes normally
    repeat (2) @(posedge clk);
    wait_cfg = 3; mv0 = n_mov_total; er0 = n_err_total;
    #1 d_req = 1'b1; t0 = cyc;
    wait_done(20, at);
    @(posedge clk); #1 d_req = 1'b0;
    chk("edge_moc_latency", at - t0, 32'd5);
    chk("edge_moc_err", n_err_total - er0, 32'd0);
    chk("edge_moc_rdata", rdata, 32'hFFFF_FFFF);
`else
    // Long memory stall: no abort
    repeat (2) @(posedge clk);
    wait_cfg = 300; mem_val = 32'h7777_1234; mv0 = n_mov_total; er0 = n_err_total;
    #1 i_addr = 32'h600; i_req = 1'b1; t0 = cyc;
    wait_done(400, at);
    @(posedge clk); #1 i_req = 1'b0;
    chk("stall_latency", at - t0, 32'd302);
    chk("stall_mov_cycles", n_mov_total - mv0, 32'd301);
    chk("stall_err", n_err_total - er0, 32'd0);
    chk("stall_rdata", rdata, 32'h7777_1234);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
